// File: rtl/switch_mcu_ex_type_u_wb.sv
// U-type execute unit with a writeback queue for the switch MCU core.
// Computes LUI/AUIPC results on the issue micro-cycle, pushes {rd, data}
// into a small FIFO and drains it to the register-file write port under a
// ready handshake. Results addressed to x0 are never queued.
// Optional build macro SWITCH_MCU_EX_TYPE_U_JAL_EN adds in_jal and queues
// the JAL link address (lowest priority after LUI and AUIPC).
module switch_mcu_ex_type_u_wb #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned ISSUE_CYCLE = 1,
  parameter int unsigned PC_OFFSET   = 8,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic [CNT_W-1:0] in_cycle_cnt,
  input  logic [XLEN-1:0]  in_pc_reg,
  input  logic             in_en,
  input  logic             in_lui,
  input  logic             in_auipc,
`ifdef SWITCH_MCU_EX_TYPE_U_JAL_EN
  input  logic             in_jal,
`endif
  input  logic [19:0]      in_imm_type_u,
  input  logic [4:0]       in_rd,
  input  logic             in_flush,
  input  logic             in_wb_ready,
  output logic [4:0]       out_waddr,
  output logic             out_wen,
  output logic [XLEN-1:0]  out_wdata,
  output logic             out_full,
  output logic             out_overflow
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StEmpty, StPartial, StFull} fifo_st_e;

  logic [4:0]      rd_mem   [FIFO_DEPTH];
  logic [XLEN-1:0] data_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  fifo_st_e        st_q, st_d;
  logic            overflow_q;

  logic signed [31:0] u_imm32;
  logic [XLEN-1:0]    u_ext;
  logic [XLEN-1:0]    pc_base;
  logic [XLEN-1:0]    res_data;
  logic               op_hit;
  logic               capture, push, pop, drop;

  assign u_imm32 = {in_imm_type_u, 12'b0};
  // Signed source makes the widening cast sign-extend from bit 31.
  assign u_ext   = XLEN'(u_imm32);
  assign pc_base = in_pc_reg - XLEN'(PC_OFFSET);

  // Result select with fixed opcode priority LUI > AUIPC > JAL.
  always_comb begin
    op_hit   = 1'b0;
    res_data = u_ext;
    if (in_lui) begin
      op_hit   = 1'b1;
      res_data = u_ext;
    end else if (in_auipc) begin
      op_hit   = 1'b1;
      res_data = u_ext + pc_base;
    end
`ifdef SWITCH_MCU_EX_TYPE_U_JAL_EN
    else if (in_jal) begin
      op_hit   = 1'b1;
      res_data = pc_base + XLEN'(4);
    end
`endif
  end

  assign capture = in_en && (in_cycle_cnt == CNT_W'(ISSUE_CYCLE)) && op_hit && !in_flush &&
                   (in_rd != 5'd0);
  assign pop     = (st_q != StEmpty) && in_wb_ready;
  // A pop frees a slot on the same edge, so a full queue can still accept.
  assign push    = capture && ((st_q != StFull) || pop);
  assign drop    = capture && (st_q == StFull) && !pop;

  // Next occupancy and queue state; flush empties the queue outright.
  always_comb begin
    cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    if (in_flush) begin
      cnt_d = '0;
    end
    if (cnt_d == '0) begin
      st_d = StEmpty;
    end else if (cnt_d == CntW'(FIFO_DEPTH)) begin
      st_d = StFull;
    end else begin
      st_d = StPartial;
    end
  end

  // Queue storage, pointers, occupancy state and sticky overflow flag.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        rd_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      st_q       <= StEmpty;
      overflow_q <= 1'b0;
    end else begin
      if (in_flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          rd_mem[wr_ptr_q]   <= in_rd;
          data_mem[wr_ptr_q] <= res_data;
          wr_ptr_q           <= wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
      end
      cnt_q <= cnt_d;
      st_q  <= st_d;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Head entry drives the write port; zeros while the queue is empty.
  always_comb begin
    out_wen   = (st_q != StEmpty);
    out_waddr = out_wen ? rd_mem[rd_ptr_q] : 5'd0;
    out_wdata = out_wen ? data_mem[rd_ptr_q] : '0;
  end

  assign out_full     = (st_q == StFull);
  assign out_overflow = overflow_q;

endmodule

// File: tb/tb_switch_mcu_ex_type_u_wb.sv
// Self-checking bench for switch_mcu_ex_type_u_wb (default FIFO_DEPTH=2).
module tb_switch_mcu_ex_type_u_wb;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic [3:0]  in_cycle_cnt;
  logic [31:0] in_pc_reg;
  logic        in_en, in_lui, in_auipc;
`ifdef SWITCH_MCU_EX_TYPE_U_JAL_EN
  logic        in_jal;
`endif
  logic [19:0] in_imm_type_u;
  logic [4:0]  in_rd;
  logic        in_flush, in_wb_ready;
  logic [4:0]  out_waddr;
  logic        out_wen;
  logic [31:0] out_wdata;
  logic        out_full, out_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 in_clk = ~in_clk;

  switch_mcu_ex_type_u_wb dut (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
    .in_cycle_cnt  (in_cycle_cnt),
    .in_pc_reg     (in_pc_reg),
    .in_en         (in_en),
    .in_lui        (in_lui),
    .in_auipc      (in_auipc),
`ifdef SWITCH_MCU_EX_TYPE_U_JAL_EN
    .in_jal        (in_jal),
`endif
    .in_imm_type_u (in_imm_type_u),
    .in_rd         (in_rd),
    .in_flush      (in_flush),
    .in_wb_ready   (in_wb_ready),
    .out_waddr     (out_waddr),
    .out_wen       (out_wen),
    .out_wdata     (out_wdata),
    .out_full      (out_full),
    .out_overflow  (out_overflow)
  );

  typedef struct {
    logic        en, lui, auipc, flush;
    logic [3:0]  cyc;
    logic [31:0] pc;
    logic [19:0] imm;
    logic [4:0]  rd;
    logic        exp_wen;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic idle();
    in_en = 1'b0; in_lui = 1'b0; in_auipc = 1'b0; in_flush = 1'b0;
    in_cycle_cnt = 4'd1; in_pc_reg = 32'h0; in_imm_type_u = 20'h0; in_rd = 5'd0;
`ifdef SWITCH_MCU_EX_TYPE_U_JAL_EN
    in_jal = 1'b0;
`endif
  endtask

  task automatic lui(input logic [19:0] imm, input logic [4:0] rd);
    idle();
    in_en = 1'b1; in_lui = 1'b1; in_imm_type_u = imm; in_rd = rd;
  endtask

  task automatic do_reset();
    #2 in_rst = 1'b0;
    #3 in_rst = 1'b1;
  endtask

  vec_t vecs [12];

  initial begin
    //           en    lui   auipc flush cyc   pc            imm       rd     wen  addr   data
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 32'h0,        20'h12345, 5'd5, 1'b1, 5'd5, 32'h12345000};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 32'h0,        20'h12345, 5'd5, 1'b0, 5'd0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 32'h108,      20'h00001, 5'd3, 1'b1, 5'd3, 32'h00001100};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 32'h8,        20'hFFFFF, 5'd7, 1'b1, 5'd7, 32'hFFFFF000};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 32'h1000,     20'hABCDE, 5'd9, 1'b1, 5'd9, 32'hABCDE000};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 32'h0,        20'h11111, 5'd0, 1'b0, 5'd0, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 32'h0,        20'h11111, 5'd4, 1'b0, 5'd0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 32'h108,      20'h11111, 5'd4, 1'b0, 5'd0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'h108,      20'h11111, 5'd6, 1'b0, 5'd0, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 32'h0,        20'h11111, 5'd6, 1'b0, 5'd0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 32'h20,       20'h80000, 5'd31, 1'b1, 5'd31, 32'h80000018};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 32'h0,        20'h00000, 5'd2, 1'b1, 5'd2, 32'h0};

    idle();
    in_wb_ready = 1'b1;
    in_rst = 1'b0;
    tick(); tick();
    chk("reset_wen", 32'(out_wen), 32'd0);
    chk("reset_waddr", 32'(out_waddr), 32'd0);
    chk("reset_wdata", out_wdata, 32'd0);
    chk("reset_full", 32'(out_full), 32'd0);
    chk("reset_overflow", 32'(out_overflow), 32'd0);
    #2 in_rst = 1'b1;

    // Ready held high: each vector's result appears one edge later and is
    // popped on the following edge.
    for (int i = 0; i < 12; i++) begin
      idle();
      in_en = vecs[i].en; in_lui = vecs[i].lui; in_auipc = vecs[i].auipc;
      in_flush = vecs[i].flush; in_cycle_cnt = vecs[i].cyc; in_pc_reg = vecs[i].pc;
      in_imm_type_u = vecs[i].imm; in_rd = vecs[i].rd;
      tick();
      chk($sformatf("vec%0d_wen", i), 32'(out_wen), 32'(vecs[i].exp_wen));
      chk($sformatf("vec%0d_waddr", i), 32'(out_waddr), 32'(vecs[i].exp_waddr));
      chk($sformatf("vec%0d_wdata", i), out_wdata, vecs[i].exp_wdata);
      chk($sformatf("vec%0d_full", i), 32'(out_full), 32'd0);
    end
    idle(); tick();
    chk("drain_wen", 32'(out_wen), 32'd0);

    // Stall: three captures into a two-entry queue.
    in_wb_ready = 1'b0;
    lui(20'h11111, 5'd1); tick();
    chk("stall1_waddr", 32'(out_waddr), 32'd1);
    chk("stall1_full", 32'(out_full), 32'd0);
    lui(20'h22222, 5'd2); tick();
    chk("stall2_full", 32'(out_full), 32'd1);
    chk("stall2_overflow", 32'(out_overflow), 32'd0);
    lui(20'h33333, 5'd3); tick();
    chk("stall3_overflow", 32'(out_overflow), 32'd1);
    chk("stall3_waddr", 32'(out_waddr), 32'd1);
    idle(); tick();
    chk("stall_hold_waddr", 32'(out_waddr), 32'd1);
    chk("stall_hold_wdata", out_wdata, 32'h11111000);
    in_wb_ready = 1'b1; tick();
    chk("drain1_waddr", 32'(out_waddr), 32'd2);
    chk("drain1_wdata", out_wdata, 32'h22222000);
    chk("drain1_full", 32'(out_full), 32'd0);
    tick();
    chk("drain2_wen", 32'(out_wen), 32'd0);
    chk("overflow_sticky", 32'(out_overflow), 32'd1);

    // Full queue with pop and push on the same edge.
    do_reset();
    in_wb_ready = 1'b0;
    lui(20'h00AAA, 5'd10); tick();
    lui(20'h00BBB, 5'd11); tick();
    chk("pp_full_before", 32'(out_full), 32'd1);
    in_wb_ready = 1'b1;
    lui(20'h00CCC, 5'd12); tick();
    chk("pp_full", 32'(out_full), 32'd1);
    chk("pp_overflow", 32'(out_overflow), 32'd0);
    chk("pp_head", 32'(out_waddr), 32'd11);
    idle(); tick();
    chk("pp_next_head", 32'(out_waddr), 32'd12);
    chk("pp_next_data", out_wdata, 32'h00CCC000);
    chk("pp_next_full", 32'(out_full), 32'd0);
    tick();
    chk("pp_empty", 32'(out_wen), 32'd0);

    // Flush with two queued entries plus a same-cycle capture and handshake.
    in_wb_ready = 1'b0;
    lui(20'h00004, 5'd4); tick();
    lui(20'h00005, 5'd5); tick();
    in_wb_ready = 1'b1;
    lui(20'h00006, 5'd6); in_flush = 1'b1; tick();
    chk("flush_wen", 32'(out_wen), 32'd0);
    chk("flush_full", 32'(out_full), 32'd0);
    idle(); tick(); tick();
    chk("flush_later_wen", 32'(out_wen), 32'd0);
    chk("flush_overflow", 32'(out_overflow), 32'd0);

    // Asynchronous reset in the middle of a stall.
    in_wb_ready = 1'b0;
    lui(20'h00008, 5'd8); tick();
    lui(20'h00009, 5'd9); tick();
    lui(20'h0000A, 5'd10); tick();
    chk("pre_rst_overflow", 32'(out_overflow), 32'd1);
    idle();
    #2 in_rst = 1'b0;
    #1;
    chk("arst_wen", 32'(out_wen), 32'd0);
    chk("arst_waddr", 32'(out_waddr), 32'd0);
    chk("arst_wdata", out_wdata, 32'd0);
    chk("arst_full", 32'(out_full), 32'd0);
    chk("arst_overflow", 32'(out_overflow), 32'd0);
    #3 in_rst = 1'b1;

`ifdef SWITCH_MCU_EX_TYPE_U_JAL_EN
    in_wb_ready = 1'b1;
    idle(); in_en = 1'b1; in_jal = 1'b1; in_pc_reg = 32'h108; in_rd = 5'd1;
    tick();
    chk("jal_waddr", 32'(out_waddr), 32'd1);
    chk("jal_wdata", out_wdata, 32'h104);
    idle(); tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
